// File: rtl/cu_fsm_mc_if.sv
// Control-unit bus for the OTTER multicycle controller.
// Groups the instruction decode inputs, interrupt/memory handshake inputs
// and all control strobes. The controller takes the master view; the
// datapath (or a testbench standing in for it) takes the slave view.
interface cu_fsm_mc_if;
  logic [6:0] IR_OPCODE;
  logic [2:0] IR_FUNCT3;
  logic       INTR;
  logic       MIE;
  logic       MEM_READY;
  logic       PC_WRITE;
  logic       REG_WRITE;
  logic       MEM_WE2;
  logic       MEM_RDEN1;
  logic       MEM_RDEN2;
  logic       CSR_WE;
  logic       INT_TAKEN;
  logic       MRET_EXEC;
  logic       ILLEGAL_OP;
  logic       MEM_FAULT;
  logic       rst;
  logic [2:0] STATE;

  modport master (
    input  IR_OPCODE, IR_FUNCT3, INTR, MIE, MEM_READY,
    output PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2, CSR_WE,
           INT_TAKEN, MRET_EXEC, ILLEGAL_OP, MEM_FAULT, rst, STATE
  );

  modport slave (
    output IR_OPCODE, IR_FUNCT3, INTR, MIE, MEM_READY,
    input  PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2, CSR_WE,
           INT_TAKEN, MRET_EXEC, ILLEGAL_OP, MEM_FAULT, rst, STATE
  );
endinterface

// File: rtl/cu_fsm_mc.sv
// Multicycle control-unit FSM for the OTTER RV32I core.
// INIT -> FETCH -> EXEC [-> WRITE_BACK] [-> INTR] -> FETCH, with
// variable-latency memory accesses, a bounded wait timeout that parks the
// machine in a sticky FAULT state, interrupt entry, MRET/CSR decode and
// a skip path for unknown opcodes. Strobes are decoded combinationally
// from the present state and the inputs, so they follow MEM_READY within
// the same cycle.
module cu_fsm_mc #(
  parameter int INTR_EN        = 1,
  parameter int MEM_HANDSHAKE  = 1,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic         CLK,
  input logic         RST,
  cu_fsm_mc_if.master bus
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_FETCH      = 3'd1,
    S_EXEC       = 3'd2,
    S_WRITE_BACK = 3'd3,
    S_INTR       = 3'd4,
    S_FAULT      = 3'd5
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] wait_cnt;
  logic          mem_ready;
  logic          intr_req;
  logic          is_mem_op;
  logic          access_pending;
  logic          timeout_hit;
  logic          instr_done;

  // Without the handshake every access finishes in its first cycle.
  assign mem_ready = (MEM_HANDSHAKE == 0) ? 1'b1 : bus.MEM_READY;
  assign intr_req  = (INTR_EN != 0) && bus.INTR && bus.MIE;
  assign is_mem_op = (bus.IR_OPCODE == OP_LOAD) || (bus.IR_OPCODE == OP_STORE);

  // A memory access is outstanding in FETCH and in EXEC of a load/store.
  assign access_pending = (state == S_FETCH) || ((state == S_EXEC) && is_mem_op);
  assign timeout_hit    = (TIMEOUT_CYCLES > 0) && access_pending && !mem_ready &&
                          (wait_cnt == TIMEOUT_VAL);

  assign bus.STATE = state;

  // Strobe decode and next-state selection from present state and inputs.
  always_comb begin
    bus.PC_WRITE   = 1'b0;
    bus.REG_WRITE  = 1'b0;
    bus.MEM_WE2    = 1'b0;
    bus.MEM_RDEN1  = 1'b0;
    bus.MEM_RDEN2  = 1'b0;
    bus.CSR_WE     = 1'b0;
    bus.INT_TAKEN  = 1'b0;
    bus.MRET_EXEC  = 1'b0;
    bus.ILLEGAL_OP = 1'b0;
    bus.MEM_FAULT  = 1'b0;
    bus.rst        = 1'b0;
    instr_done     = 1'b0;
    next_state     = state;

    case (state)
      S_INIT: begin
        bus.rst    = 1'b1;
        next_state = S_FETCH;
      end

      S_FETCH: begin
        bus.MEM_RDEN1 = 1'b1;
        if (timeout_hit) begin
          next_state = S_FAULT;
        end else if (mem_ready) begin
          next_state = S_EXEC;
        end
      end

      S_EXEC: begin
        case (bus.IR_OPCODE)
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG: begin
            bus.PC_WRITE  = 1'b1;
            bus.REG_WRITE = 1'b1;
            instr_done    = 1'b1;
          end
          OP_BRANCH: begin
            bus.PC_WRITE = 1'b1;
            instr_done   = 1'b1;
          end
          OP_SYSTEM: begin
            bus.PC_WRITE = 1'b1;
            instr_done   = 1'b1;
            if (bus.IR_FUNCT3 == 3'b000) begin
              bus.MRET_EXEC = 1'b1;
            end else begin
              bus.CSR_WE    = 1'b1;
              bus.REG_WRITE = 1'b1;
            end
          end
          OP_STORE: begin
            bus.MEM_WE2 = 1'b1;
            if (mem_ready) begin
              bus.PC_WRITE = 1'b1;
              instr_done   = 1'b1;
            end else if (timeout_hit) begin
              next_state = S_FAULT;
            end
          end
          OP_LOAD: begin
            bus.MEM_RDEN2 = 1'b1;
            if (mem_ready) begin
              next_state = S_WRITE_BACK;
            end else if (timeout_hit) begin
              next_state = S_FAULT;
            end
          end
          default: begin
            bus.ILLEGAL_OP = 1'b1;
            bus.PC_WRITE   = 1'b1;
            instr_done     = 1'b1;
          end
        endcase
      end

      S_WRITE_BACK: begin
        bus.PC_WRITE  = 1'b1;
        bus.REG_WRITE = 1'b1;
        instr_done    = 1'b1;
      end

      S_INTR: begin
        bus.INT_TAKEN = 1'b1;
        bus.PC_WRITE  = 1'b1;
        next_state    = S_FETCH;
      end

      S_FAULT: begin
        bus.MEM_FAULT = 1'b1;
        next_state    = S_FAULT;
      end

      default: begin
        next_state = S_INIT;
      end
    endcase

    // Interrupts are only taken at an instruction boundary.
    if (instr_done) begin
      next_state = intr_req ? S_INTR : S_FETCH;
    end
  end

  // State register plus the per-access wait counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_INIT;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if ((next_state != state) || mem_ready || !access_pending) begin
        wait_cnt <= '0;
      end else if (wait_cnt != '1) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule
